ime_pe_feeder: RTL and testbench
================================

Name: ime_pe_feeder

Overview:
- Operand feeder for one 4x4 SAD processing element in the IME datapath.
- Latches a 4x4 current block and streams every 4x4 candidate of a WIN_W x WIN_H reference window into the PE's current-block, reference-block and enable inputs, one candidate per cycle.
- Emits candidate-position tags delayed to line up with the PE's 2-cycle SAD output, so the downstream min-SAD logic can pair each SAD with its motion vector.
- Reads the reference window row by row from a 1-cycle-latency row memory.

Parameters:
BIT_DEPTH, 8, bits per pixel
WIN_W, 16, reference window width in pixels (one memory row); horizontal positions = WIN_W-3
WIN_H, 16, reference window height in rows; vertical positions = WIN_H-3
ADDR_W, 4, row address width (2^ADDR_W >= WIN_H)
POS_W, 4, candidate coordinate width (2^POS_W >= WIN_W-3)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous reset, active low
start_i  in  1  start pulse; accepted only in IDLE
cur4x4_i  in  16*BIT_DEPTH  current 4x4 block; sampled in the start cycle
ref_rd_en_o  out  1  row memory read strobe
ref_rd_addr_o  out  ADDR_W  window row index
ref_rd_data_i  in  WIN_W*BIT_DEPTH  row data; valid the cycle after ref_rd_en_o
cmb4x4_o  out  16*BIT_DEPTH  current block to PE
ref4x4_o  out  16*BIT_DEPTH  candidate block to PE
enable_o  out  1  candidate valid to PE
cand_x_o  out  POS_W  dx of the SAD currently at PE output
cand_y_o  out  POS_W  dy of the SAD currently at PE output
tag_valid_o  out  1  PE SAD output corresponds to a candidate
busy_o  out  1  high from the cycle after start until done inclusive
done_o  out  1  one-cycle pulse coincident with the last tag_valid_o

Behaviour:
- Reset is asynchronous and active-low on rstn; clock is clk. On reset: all outputs 0, FSM to IDLE, row buffer and tag pipeline cleared. Reset mid-scan aborts the scan with no done_o pulse.
- Pixel packing in 4x4 buses: pixel i occupies bits [(i+1)*BIT_DEPTH-1 : i*BIT_DEPTH], with row = i/4 and col = i%4.
- Row packing: column c occupies bits [(c+1)*BIT_DEPTH-1 : c*BIT_DEPTH].
- FSM states: IDLE, FETCH, CAPTURE, SCAN, DONE.
- IDLE: when start_i=1, latch cur4x4_i into cmb4x4_o, clear the row counter and dy, then go to FETCH. start_i in any other state is ignored.
- FETCH: ref_rd_en_o=1 with ref_rd_addr_o = row counter; go to CAPTURE.
- CAPTURE: shift the 4-row buffer (row0<=row1, row1<=row2, row2<=row3, row3<=ref_rd_data_i) and increment the row counter.
  - Fewer than 4 rows loaded: go to FETCH.
  - Otherwise: go to SCAN with dx=0.
- SCAN: one cycle per dx, for dx = 0..WIN_W-4.
  - Registered outputs on the next edge: ref4x4_o = buffer rows 0..3, columns dx..dx+3; enable_o=1; tag stage0 = {1, dx, dy}.
  - After dx = WIN_W-4: if dy = WIN_H-4, go to DONE; else dy++ and go to FETCH for the next row.
- Outside the cycle following a SCAN cycle: enable_o=0; ref4x4_o and cmb4x4_o hold their values.
- Tag pipeline: {valid, dx, dy} passes through 2 registers so that tag_valid_o/cand_x_o/cand_y_o appear exactly 2 cycles after the matching enable_o. This matches the PE (sad2x2 register, then sad4x4 register).
- DONE: wait until the tag pipeline drains. done_o pulses with the final tag_valid_o, then the FSM returns to IDLE. busy_o drops the cycle after done_o.
- Timing for defaults, start in cycle 0:
  - Preload FETCH/CAPTURE pairs: cycles 1-8.
  - First SCAN: cycle 9; first enable_o: cycle 10; first tag_valid_o: cycle 12.
  - Each later row costs 15 cycles (2 fetch + 13 scan). Last SCAN: cycle 201; last enable_o: cycle 202; done_o: cycle 204.
  - 169 candidates total.
- ref_rd_en_o is high only in FETCH. At most WIN_H reads are issued, addresses 0..WIN_H-1 in order.

Test Plan:
- Reset/idle: hold rstn low, then release with no start -> all outputs 0, busy_o=0, ref_rd_en_o never asserted.
- Nominal scan: window pixel(x,y) = (x+16y) mod 256, cur block all 0, start at cycle 0 -> 169 enable_o pulses. First enable_o at cycle 10 with ref4x4_o pixel0..3 = 0,1,2,3. tag_valid_o at 12 with dx=0, dy=0. done_o at 204.
- Ordering/wrap: same stimulus -> tags go dx 0..12 then dy increments. After the dx=12,dy=0 candidate the next candidate is dx=0,dy=1 with ref4x4_o pixel0 = 16. Reads use addresses 0..15, each exactly once.
- PE alignment: connect a PE model, cur block = window rows 5..8, cols 7..10 -> exactly one SAD=0, with tag dx=7, dy=5.
- Start while busy: pulse start_i at cycle 50 -> ignored; cmb4x4_o unchanged; done_o still at 204.
- Mid-scan reset: assert rstn low at cycle 100, release, restart -> no done_o from the aborted run; the new run reproduces nominal timing relative to its own start.

Source files
------------

// File: rtl/ime_pe_feeder_if.sv
// Signal bundle between the SAD operand feeder and its environment.
// The environment is the start/current-block source, the reference row memory,
// the 4x4 SAD PE and the min-SAD tracker.
// The master modport is the feeder itself. The slave modport is everything around it.
interface ime_pe_feeder_if #(
  parameter int BIT_DEPTH = 8,
  parameter int WIN_W     = 16,
  parameter int ADDR_W    = 4,
  parameter int POS_W     = 4
);
  // Control and current block
  logic                       start_i;
  logic [16*BIT_DEPTH-1:0]    cur4x4_i;

  // Reference row memory (1-cycle read latency)
  logic                       ref_rd_en_o;
  logic [ADDR_W-1:0]          ref_rd_addr_o;
  logic [WIN_W*BIT_DEPTH-1:0] ref_rd_data_i;

  // PE operands
  logic [16*BIT_DEPTH-1:0]    cmb4x4_o;
  logic [16*BIT_DEPTH-1:0]    ref4x4_o;
  logic                       enable_o;

  // Candidate tags aligned with the PE's SAD output
  logic [POS_W-1:0]           cand_x_o;
  logic [POS_W-1:0]           cand_y_o;
  logic                       tag_valid_o;

  // Status
  logic                       busy_o;
  logic                       done_o;

  modport master (
    input  start_i, cur4x4_i, ref_rd_data_i,
    output ref_rd_en_o, ref_rd_addr_o,
    output cmb4x4_o, ref4x4_o, enable_o,
    output cand_x_o, cand_y_o, tag_valid_o,
    output busy_o, done_o
  );

  modport slave (
    output start_i, cur4x4_i, ref_rd_data_i,
    input  ref_rd_en_o, ref_rd_addr_o,
    input  cmb4x4_o, ref4x4_o, enable_o,
    input  cand_x_o, cand_y_o, tag_valid_o,
    input  busy_o, done_o
  );
endinterface

// File: rtl/ime_pe_feeder.sv
// Operand feeder for one 4x4 SAD processing element.
// It latches the current block and pulls the reference window in one row at a time.
// A 4-row sliding buffer holds the rows, and every 4x4 candidate is presented one per cycle.
// Each candidate carries an {x,y} tag, delayed two cycles to line up with the PE's SAD output.
module ime_pe_feeder #(
  parameter int BIT_DEPTH = 8,
  parameter int WIN_W     = 16,
  parameter int WIN_H     = 16,
  parameter int ADDR_W    = 4,
  parameter int POS_W     = 4
) (
  input  logic            clk,
  input  logic            rstn,
  ime_pe_feeder_if.master bus
);

  localparam int BLK_W   = 16 * BIT_DEPTH;
  localparam int ROW_W   = WIN_W * BIT_DEPTH;
  // One extra bit so the count can reach WIN_H after the last row is loaded
  localparam int CNT_W   = ADDR_W + 1;
  localparam int LAST_DX = WIN_W - 4;
  localparam int LAST_DY = WIN_H - 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_SCAN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } tag_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [ROW_W-1:0] r_row [4];
  logic [CNT_W-1:0] r_row_cnt;
  logic [CNT_W-1:0] w_row_cnt_inc;
  logic [POS_W-1:0] r_dx;
  logic [POS_W-1:0] r_dy;

  logic [BLK_W-1:0] r_cmb;
  logic [BLK_W-1:0] r_ref;
  logic [BLK_W-1:0] w_ref_win;
  logic             r_enable;

  tag_t             r_tag0;
  tag_t             r_tag1;
  tag_t             r_tag2;

  logic             w_rows_ready;
  logic             w_last_dx;
  logic             w_last_dy;
  logic             w_drained;

  assign w_row_cnt_inc = r_row_cnt + 1'b1;
  // At least four rows will be in the buffer once this CAPTURE completes
  assign w_rows_ready  = (w_row_cnt_inc >= CNT_W'(4));
  assign w_last_dx     = (r_dx == POS_W'(LAST_DX));
  assign w_last_dy     = (r_dy == POS_W'(LAST_DY));
  // Only the final candidate's tag is still in flight: it sits in the last stage and nothing follows it
  assign w_drained     = r_tag2.valid && !r_tag1.valid && !r_tag0.valid;

  // State register
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample the same pre-edge values; blocking would make results order-dependent.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: preload four rows, then alternate one-row fetch with one scan line
  // NOTE: the default is assigned before the case so every path drives
  // w_state_nxt; a missing branch would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_state_nxt = w_rows_ready ? S_SCAN : S_FETCH;
      end
      S_SCAN: begin
        if (w_last_dx) begin
          w_state_nxt = w_last_dy ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        if (w_drained) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sliding row buffer, row counter, candidate position and latched current block
  // NOTE: the row buffer is only four flop rows, not a RAM macro, so it is
  // cleared on reset like any other register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cmb     <= '0;
      r_row_cnt <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
      for (int i = 0; i < 4; i++) begin
        r_row[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_cmb     <= bus.cur4x4_i;
            r_row_cnt <= '0;
            r_dx      <= '0;
            r_dy      <= '0;
          end
        end
        S_CAPTURE: begin
          // The memory returns the row fetched in the previous cycle; the oldest row drops out
          r_row[0]  <= r_row[1];
          r_row[1]  <= r_row[2];
          r_row[2]  <= r_row[3];
          r_row[3]  <= bus.ref_rd_data_i;
          r_row_cnt <= w_row_cnt_inc;
          r_dx      <= '0;
        end
        S_SCAN: begin
          if (w_last_dx) begin
            r_dx <= '0;
            if (!w_last_dy) begin
              r_dy <= r_dy + 1'b1;
            end
          end else begin
            r_dx <= r_dx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Candidate window select: pixel p takes buffer row p/4, column dx + p%4
  always_comb begin
    w_ref_win = '0;
    for (int p = 0; p < 16; p++) begin
      w_ref_win[p*BIT_DEPTH +: BIT_DEPTH] =
        r_row[p/4][(int'(r_dx) + p % 4) * BIT_DEPTH +: BIT_DEPTH];
    end
  end

  // PE operand registers and the candidate tag pipeline
  // The two tag stages after stage0 mirror the PE's 2x2 and 4x4 SAD registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ref    <= '0;
      r_enable <= 1'b0;
      r_tag0   <= '0;
      r_tag1   <= '0;
      r_tag2   <= '0;
    end else begin
      r_enable <= (r_state == S_SCAN);
      if (r_state == S_SCAN) begin
        r_ref        <= w_ref_win;
        r_tag0.valid <= 1'b1;
        r_tag0.x     <= r_dx;
        r_tag0.y     <= r_dy;
      end else begin
        r_tag0       <= '0;
      end
      r_tag1 <= r_tag0;
      r_tag2 <= r_tag1;
    end
  end

  // The read strobe and address are decoded straight from the state; the memory registers them
  assign bus.ref_rd_en_o   = (r_state == S_FETCH);
  assign bus.ref_rd_addr_o = (r_state == S_FETCH) ? r_row_cnt[ADDR_W-1:0] : '0;

  assign bus.cmb4x4_o      = r_cmb;
  assign bus.ref4x4_o      = r_ref;
  assign bus.enable_o      = r_enable;

  assign bus.tag_valid_o   = r_tag2.valid;
  assign bus.cand_x_o      = r_tag2.x;
  assign bus.cand_y_o      = r_tag2.y;

  assign bus.busy_o        = (r_state != S_IDLE);
  assign bus.done_o        = (r_state == S_DONE) && w_drained;

endmodule

// File: tb/tb_ime_pe_feeder.sv
// Self-checking bench for ime_pe_feeder.
// Expected outputs come from a timing model built on candidate indices:
// candidate (dx,dy) is presented at start+10+15*dy+dx and tagged two cycles later.
// The bench also models the row memory and a 2-stage SAD PE.
module tb_ime_pe_feeder;

  localparam int BD       = 8;
  localparam int WIN_W    = 16;
  localparam int WIN_H    = 16;
  localparam int ADDR_W   = 4;
  localparam int POS_W    = 4;
  localparam int BLK_W    = 16 * BD;
  localparam int ROW_W    = WIN_W * BD;
  localparam int NX       = WIN_W - 3;
  localparam int NY       = WIN_H - 3;
  localparam int ROW_T    = NX + 2;
  localparam int FIRST_EN = 10;
  localparam int DONE_T   = FIRST_EN + ROW_T * (NY - 1) + (NX - 1) + 2;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   cyc  = 0;
  int   checks = 0;
  int   failures = 0;

  ime_pe_feeder_if #(.BIT_DEPTH(BD), .WIN_W(WIN_W), .ADDR_W(ADDR_W), .POS_W(POS_W)) bus ();

  ime_pe_feeder #(
    .BIT_DEPTH(BD), .WIN_W(WIN_W), .WIN_H(WIN_H), .ADDR_W(ADDR_W), .POS_W(POS_W)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference window contents
  logic [BD-1:0] win [WIN_H][WIN_W];

  function automatic logic [ROW_W-1:0] pack_row(input int r);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int c = 0; c < WIN_W; c++) v[c*BD +: BD] = win[r][c];
    return v;
  endfunction

  function automatic logic [BLK_W-1:0] exp_block(input int dx, input int dy);
    logic [BLK_W-1:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*BD +: BD] = win[dy + i/4][dx + i%4];
    return v;
  endfunction

  function automatic logic [BLK_W-1:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Candidate index u (cycles since the first enable) -> position, if a candidate is live then
  function automatic bit cand_at(input int u, output int dx, output int dy);
    dx = 0;
    dy = 0;
    if (u < 0) return 1'b0;
    dy = u / ROW_T;
    dx = u % ROW_T;
    return (dx < NX) && (dy < NY);
  endfunction

  function automatic int sad(input logic [BLK_W-1:0] a, input logic [BLK_W-1:0] b);
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) begin
      int d;
      d = int'(a[i*BD +: BD]) - int'(b[i*BD +: BD]);
      s += (d < 0) ? -d : d;
    end
    return s;
  endfunction

  // Row memory: one-cycle read latency, unrelated data whenever no read was issued
  always @(posedge clk) begin
    if (bus.ref_rd_en_o) bus.ref_rd_data_i <= pack_row(int'(bus.ref_rd_addr_o));
    else                 bus.ref_rd_data_i <= {$urandom, $urandom, $urandom, $urandom};
  end

  // PE: first register holds the 2x2 partials, the second holds the 4x4 SAD (-1 = no candidate)
  int pe_s1 = -1;
  int pe_s2 = -1;
  always @(posedge clk) begin
    pe_s1 <= bus.enable_o ? sad(bus.cmb4x4_o, bus.ref4x4_o) : -1;
    pe_s2 <= pe_s1;
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0b, expected %0b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_blk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Run bookkeeping and per-run observations
  logic             run_active = 1'b0;
  int               run_start  = 0;
  logic [BLK_W-1:0] run_cur    = '0;
  int               en_cnt, done_cnt, done_t, first_en_t, rd_total;
  int               rd_hits [WIN_H];
  int               zero_cnt, zero_x, zero_y;
  logic [BLK_W-1:0] ref_at_first, ref_at_row1;
  int               tag_first, tag_row0_end, tag_row1_start;

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    int   t, dx, dy, e_addr;
    logic e_en, e_tag, e_rd;
    if (run_active && (cyc - run_start) > DONE_T) run_active = 1'b0;
    if (bus.done_o) done_cnt++;
    if (run_active) begin
      t = cyc - run_start;
      check_bit("busy", bus.busy_o, (t >= 1) && (t <= DONE_T));
      check_bit("done", bus.done_o, t == DONE_T);
      if (bus.done_o) done_t = t;
      if (t >= 1) check_blk("cmb4x4", bus.cmb4x4_o, run_cur);

      // Four preload reads on odd cycles 1..7, then row dy+3 two cycles before scan line dy
      e_rd = 1'b0;
      e_addr = 0;
      if (t >= 1 && t <= 8 && (t % 2) == 1) begin
        e_rd = 1'b1;
        e_addr = (t - 1) / 2;
      end
      for (int r = 1; r < NY; r++) begin
        if (t == FIRST_EN - 1 + ROW_T * r - 2) begin
          e_rd = 1'b1;
          e_addr = r + 3;
        end
      end
      check_bit("rd_en", bus.ref_rd_en_o, e_rd);
      if (e_rd) check_int("rd_addr", int'(bus.ref_rd_addr_o), e_addr);
      if (bus.ref_rd_en_o) begin
        rd_total++;
        rd_hits[int'(bus.ref_rd_addr_o)]++;
      end

      e_en = cand_at(t - FIRST_EN, dx, dy);
      check_bit("enable", bus.enable_o, e_en);
      if (e_en) check_blk("ref4x4", bus.ref4x4_o, exp_block(dx, dy));
      if (bus.enable_o) begin
        en_cnt++;
        if (first_en_t < 0) first_en_t = t;
      end
      if (t == FIRST_EN)         ref_at_first = bus.ref4x4_o;
      if (t == FIRST_EN + ROW_T) ref_at_row1  = bus.ref4x4_o;

      e_tag = cand_at(t - FIRST_EN - 2, dx, dy);
      check_bit("tag_valid", bus.tag_valid_o, e_tag);
      if (e_tag) begin
        check_int("cand_x", int'(bus.cand_x_o), dx);
        check_int("cand_y", int'(bus.cand_y_o), dy);
      end
      if (t == FIRST_EN + 2)              tag_first      = int'({bus.tag_valid_o, bus.cand_x_o, bus.cand_y_o});
      if (t == FIRST_EN + 2 + NX - 1)     tag_row0_end   = int'({bus.tag_valid_o, bus.cand_x_o, bus.cand_y_o});
      if (t == FIRST_EN + 2 + ROW_T)      tag_row1_start = int'({bus.tag_valid_o, bus.cand_x_o, bus.cand_y_o});
      if (bus.tag_valid_o && pe_s2 == 0) begin
        zero_cnt++;
        zero_x = int'(bus.cand_x_o);
        zero_y = int'(bus.cand_y_o);
      end
    end else begin
      check_bit("idle_busy",   bus.busy_o,      1'b0);
      check_bit("idle_done",   bus.done_o,      1'b0);
      check_bit("idle_enable", bus.enable_o,    1'b0);
      check_bit("idle_rd_en",  bus.ref_rd_en_o, 1'b0);
      check_bit("idle_tag",    bus.tag_valid_o, 1'b0);
    end
  end

  task automatic clear_stats();
    en_cnt = 0; done_cnt = 0; done_t = -1; first_en_t = -1; rd_total = 0;
    zero_cnt = 0; zero_x = -1; zero_y = -1;
    tag_first = -1; tag_row0_end = -1; tag_row1_start = -1;
    ref_at_first = '0; ref_at_row1 = '0;
    for (int i = 0; i < WIN_H; i++) rd_hits[i] = 0;
  endtask

  // Start pulse lasts the whole cycle numbered 0 of the run
  task automatic start_run(input logic [BLK_W-1:0] cur);
    @(posedge clk);
    #1;
    clear_stats();
    run_start    = cyc;
    run_cur      = cur;
    run_active   = 1'b1;
    bus.start_i  = 1'b1;
    bus.cur4x4_i = cur;
    @(posedge clk);
    #1;
    bus.start_i  = 1'b0;
    bus.cur4x4_i = rand_blk();
  endtask

  // Bounded by the cycle count alone; a missing done shows up in the done checks
  task automatic finish_run();
    while (cyc - run_start <= DONE_T + 2) @(posedge clk);
    #1;
  endtask

  task automatic fill_nominal();
    for (int y = 0; y < WIN_H; y++)
      for (int x = 0; x < WIN_W; x++) win[y][x] = BD'((x + 16 * y) % 256);
  endtask

  task automatic fill_random();
    for (int y = 0; y < WIN_H; y++)
      for (int x = 0; x < WIN_W; x++) win[y][x] = BD'($urandom_range(0, 255));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i  = 1'b0;
    bus.cur4x4_i = '0;
    clear_stats();

    // Reset and idle
    #1 rstn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_blk("rst_cmb", bus.cmb4x4_o, '0);
    check_blk("rst_ref", bus.ref4x4_o, '0);
    check_int("rst_cand", int'({bus.cand_x_o, bus.cand_y_o}), 0);
    rstn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_blk("idle_cmb", bus.cmb4x4_o, '0);
    check_blk("idle_ref", bus.ref4x4_o, '0);
    check_int("idle_rd_addr", int'(bus.ref_rd_addr_o), 0);

    // Nominal scan, with a stray start at cycle 50 that must be ignored
    fill_nominal();
    start_run('0);
    repeat (49) @(posedge clk);
    #1;
    bus.start_i  = 1'b1;
    bus.cur4x4_i = rand_blk();
    @(posedge clk);
    #1;
    bus.start_i  = 1'b0;
    finish_run();
    check_int("lit_first_en", first_en_t, 10);
    check_int("lit_done_t", done_t, 204);
    check_int("lit_done_cnt", done_cnt, 1);
    check_int("lit_en_cnt", en_cnt, 169);
    check_int("lit_px0_3", int'(ref_at_first[31:0]), 32'h03020100);
    check_int("lit_row1_px0", int'(ref_at_row1[7:0]), 16);
    check_int("lit_tag_first", tag_first, 256);
    check_int("lit_tag_row0_end", tag_row0_end, 256 + 12 * 16);
    check_int("lit_tag_row1_start", tag_row1_start, 257);
    check_int("lit_rd_total", rd_total, 16);
    for (int a = 0; a < WIN_H; a++) check_int("lit_rd_hits", rd_hits[a], 1);
    check_blk("busy_start_cmb", bus.cmb4x4_o, '0);

    // PE alignment: the current block is the window block at (7,5)
    start_run(exp_block(7, 5));
    finish_run();
    check_int("pe_zero_cnt", zero_cnt, 1);
    check_int("pe_zero_x", zero_x, 7);
    check_int("pe_zero_y", zero_y, 5);

    // Randomized windows and current blocks
    for (int k = 0; k < 3; k++) begin
      fill_random();
      repeat ($urandom_range(1, 5)) @(posedge clk);
      start_run(rand_blk());
      finish_run();
      check_int("rand_en_cnt", en_cnt, NX * NY);
      check_int("rand_done_cnt", done_cnt, 1);
    end

    // Reset at cycle 100 aborts the scan; a fresh run must keep nominal timing
    fill_nominal();
    start_run(rand_blk());
    repeat (99) @(posedge clk);
    #1;
    run_active = 1'b0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_blk("abort_cmb_cleared", bus.cmb4x4_o, '0);
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_int("abort_no_done", done_cnt, 0);
    start_run('0);
    finish_run();
    check_int("restart_first_en", first_en_t, 10);
    check_int("restart_done_t", done_t, 204);
    check_int("restart_en_cnt", en_cnt, 169);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
